// File: rtl/conv_window_loader.sv
// conv_window_loader
// Streams a filter (optional) and an image window into two packed operand
// vectors, pulses the conv unit through reset, waits out its fixed latency,
// captures the accumulator and presents it on a result handshake.
//
// Handshake semantics (all three channels): a beat transfers on a rising
// clk edge where valid and ready are both high. ready depends only on the
// current state, never on valid, so there is no combinational loop through
// the block. A producer holds valid and its payload until the transfer.
module conv_window_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int F          = 5,
  parameter int N          = D * F * F,
  parameter int LAT        = D * F * F + 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic                      cmd_filter,
  output logic                      cmd_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [0:N*DATA_WIDTH-1]   image_vec,
  output logic [0:N*DATA_WIDTH-1]   filter_vec,
  output logic                      conv_reset,
  input  logic [DATA_WIDTH-1:0]     conv_result,
  output logic [DATA_WIDTH-1:0]     res_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      busy,
  output logic [2:0]                dbg_state
);

  // Element counter spans 0..N-1; wait counter spans 0..LAT.
  localparam int EW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(LAT + 1);

  localparam logic [EW-1:0] ELEM_LAST = EW'(N - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(LAT);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
  localparam logic [EW-1:0] ELEM_ONE  = EW'(1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_FILTER = 3'd1,
    S_LOAD_IMAGE  = 3'd2,
    S_FIRE        = 3'd3,
    S_WAIT        = 3'd4,
    S_DONE        = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [EW-1:0]             elem_cnt_q, elem_cnt_d;
  logic [WW-1:0]             wait_cnt_q, wait_cnt_d;
  logic [0:N*DATA_WIDTH-1]   image_q, image_d;
  logic [0:N*DATA_WIDTH-1]   filter_q, filter_d;
  logic [DATA_WIDTH-1:0]     res_q, res_d;

  logic xfer;
  logic last_elem;
  logic wait_done;

  // Shared decode of the element transfer and the end of the latency window.
  always_comb begin
    xfer      = in_valid && ((state_q == S_LOAD_FILTER) || (state_q == S_LOAD_IMAGE));
    last_elem = xfer && (elem_cnt_q == ELEM_LAST);
    wait_done = (state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST);
  end

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (cmd_valid) state_d = cmd_filter ? S_LOAD_FILTER : S_LOAD_IMAGE;
      S_LOAD_FILTER: if (last_elem) state_d = S_LOAD_IMAGE;
      S_LOAD_IMAGE:  if (last_elem) state_d = S_FIRE;
      S_FIRE:        state_d = S_WAIT;
      S_WAIT:        if (wait_done) state_d = S_DONE;
      S_DONE:        if (res_ready) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    conv_reset = 1'b1;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD_FILTER, S_LOAD_IMAGE: in_ready   = 1'b1;
      S_WAIT:                      conv_reset = 1'b0;
      S_DONE:                      res_valid  = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: element counter, latency counter, vector writes
  // and result capture.
  always_comb begin
    elem_cnt_d = elem_cnt_q;
    wait_cnt_d = '0;
    image_d    = image_q;
    filter_d   = filter_q;
    res_d      = res_q;

    // The counter is zero whenever a LOAD state is entered: it is cleared
    // from IDLE and on the final transfer of each load.
    if (state_q == S_IDLE) begin
      elem_cnt_d = '0;
    end else if (xfer) begin
      elem_cnt_d = last_elem ? '0 : elem_cnt_q + ELEM_ONE;
    end

    if (xfer && (state_q == S_LOAD_FILTER)) begin
      filter_d[int'(elem_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end
    if (xfer && (state_q == S_LOAD_IMAGE)) begin
      image_d[int'(elem_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    // Counter reads 1 in the first WAIT cycle and LAT in the last one.
    if (state_q == S_FIRE) begin
      wait_cnt_d = WAIT_ONE;
    end else if ((state_q == S_WAIT) && !wait_done) begin
      wait_cnt_d = wait_cnt_q + WAIT_ONE;
    end

    if (wait_done) begin
      res_d = conv_result;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_cnt_q <= '0;
      wait_cnt_q <= '0;
      image_q    <= '0;
      filter_q   <= '0;
      res_q      <= '0;
    end else begin
      elem_cnt_q <= elem_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      image_q    <= image_d;
      filter_q   <= filter_d;
      res_q      <= res_d;
    end
  end

  assign image_vec  = image_q;
  assign filter_vec = filter_q;
  assign res_data   = res_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv_window_loader.sv
// Bench for conv_window_loader: table of jobs plus hand-written sequences for
// idle noise and asynchronous reset mid-job. conv_result is a known function
// of the bench cycle count, so the captured value is predictable from the
// cycle in which the last element was driven.
module tb_conv_window_loader;

  localparam int DW  = 16;
  localparam int D   = 1;
  localparam int F   = 5;
  localparam int N   = D * F * F;
  localparam int LAT = N + 2;
  localparam int NW  = N * DW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_filter = 1'b0;
  logic            cmd_ready;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [0:NW-1]   image_vec;
  logic [0:NW-1]   filter_vec;
  logic            conv_reset;
  logic [DW-1:0]   conv_result;
  logic [DW-1:0]   res_data;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic            busy;
  logic [2:0]      dbg_state;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  logic [0:NW-1] filter_m;
  logic [0:NW-1] image_m;

  typedef struct {
    bit with_filter;
    bit gaps;
    int stall;
    bit noise;
    int exp_len;
  } job_t;

  job_t jobs[5];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] g(input int c);
    logic [31:0] p;
    p = c * 40503 + 12345;
    return p[DW-1:0];
  endfunction

  assign conv_result = g(cyc);

  conv_window_loader #(.DATA_WIDTH(DW), .D(D), .F(F)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_filter  (cmd_filter),
    .cmd_ready   (cmd_ready),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .image_vec   (image_vec),
    .filter_vec  (filter_vec),
    .conv_reset  (conv_reset),
    .conv_result (conv_result),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},      dbg_state, 0);
    chk({tag, "_cmd_ready"},  cmd_ready, 1);
    chk({tag, "_in_ready"},   in_ready, 0);
    chk({tag, "_conv_reset"}, conv_reset, 1);
    chk({tag, "_res_valid"},  res_valid, 0);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_res_data"},   res_data, 0);
    chk({tag, "_image_vec"},  image_vec, 0);
    chk({tag, "_filter_vec"}, filter_vec, 0);
  endtask

  // ---------------- driver tasks ----------------
  // Accepts a command and streams the elements; returns the accept cycle and
  // the cycle of the last transfer edge (pre-increment cyc values).
  task automatic load_phase(input bit with_filter, input bit gaps,
                            output int acc_cyc, output int last_cyc, output bit ok);
    int guard;
    int total;
    int k;
    bit is_filt;
    logic [DW-1:0] d;
    ok = 1'b1;
    acc_cyc = 0;
    last_cyc = 0;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      step();
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
      ok = 1'b0;
      return;
    end
    cmd_valid = 1'b1;
    cmd_filter = with_filter;
    acc_cyc = cyc;
    step();
    cmd_valid = 1'b0;
    cmd_filter = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_state", dbg_state, with_filter ? 1 : 2);
    total = with_filter ? 2 * N : N;
    for (int i = 0; i < total; i++) begin
      is_filt = with_filter && (i < N);
      k = (with_filter && i >= N) ? i - N : i;
      d = is_filt ? DW'(16'h3C00 + k) : DW'(16'h4000 + k);
      if (gaps) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data = d;
      guard = 0;
      while (!in_ready && guard < 100) begin
        step();
        guard++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      last_cyc = cyc;
      step();
      if (is_filt) filter_m[k*DW +: DW] = d;
      else         image_m[k*DW +: DW] = d;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    int a;
    int t;
    int lows;
    int bad_ready;
    int bad_stall;
    bit ok;
    logic [DW-1:0] exp;
    load_phase(j.with_filter, j.gaps, a, t, ok);
    if (!ok) return;
    exp_q.push_back(g(t + 1 + LAT));
    chk("fire_state", dbg_state, 3);
    chk("fire_conv_reset", conv_reset, 1);
    lows = 0;
    bad_ready = 0;
    for (int w = 0; w < LAT; w++) begin
      if (j.noise) begin
        in_valid = 1'b1;
        in_data = DW'($urandom_range(0, 65535));
      end
      step();
      if (conv_reset === 1'b0) lows++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    in_valid = 1'b0;
    chk("wait_low_cycles", lows, LAT);
    chk("wait_in_ready", bad_ready, 0);
    step();
    chk("job_len", cyc - a - 1, j.exp_len);
    chk("done_res_valid", res_valid, 1);
    chk("done_conv_reset", conv_reset, 1);
    chk("done_cmd_ready", cmd_ready, 0);
    chk("filter_vec", filter_vec, filter_m);
    chk("image_vec", image_vec, image_m);
    if (j.with_filter) begin
      chk("filter_elem0", filter_vec[0:15], 16'h3C00);
      chk("image_elem24", image_vec[384:399], 16'h4018);
    end
    exp = exp_q[0];
    bad_stall = 0;
    for (int s = 0; s < j.stall; s++) begin
      step();
      if (res_valid !== 1'b1 || res_data !== exp || cmd_ready !== 1'b0) bad_stall++;
    end
    chk("stall_hold", bad_stall, 0);
    res_ready = 1'b1;
    chk("res_valid_at_ack", res_valid, 1);
    chk("res_data", res_data, exp_q.pop_front());
    step();
    res_ready = 1'b0;
    chk("ack_state_idle", dbg_state, 0);
    chk("ack_cmd_ready", cmd_ready, 1);
    chk("ack_res_valid", res_valid, 0);
    chk("ack_busy", busy, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int a;
    int t;
    int bad;
    bit ok;

    jobs[0] = '{0, 0, 0,  0, 53};   // image only straight after reset
    jobs[1] = '{1, 0, 0,  0, 78};   // full job, no gaps
    jobs[2] = '{1, 1, 0,  0, 128};  // in_valid toggled, 50 extra cycles
    jobs[3] = '{1, 0, 10, 0, 78};   // result stall
    jobs[4] = '{0, 0, 0,  1, 53};   // filter reuse, noise during WAIT

    filter_m = '0;
    image_m  = '0;

    // Reset held low across a clock edge.
    #12;
    chk_reset_values("por");
    #6;
    reset = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      run_job(jobs[i]);
    end

    // Idle noise: in_valid with random data must be ignored.
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = DW'($urandom_range(0, 65535));
      step();
      if (in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    chk("idle_in_ready", bad, 0);
    chk("idle_filter_vec", filter_vec, filter_m);
    chk("idle_image_vec", image_vec, image_m);

    // Asynchronous reset in WAIT cycle 10, away from any clock edge.
    load_phase(1'b1, 1'b0, a, t, ok);
    if (ok) begin
      for (int i = 0; i < 10; i++) step();
      chk("pre_reset_state", dbg_state, 4);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_values("async");
      filter_m = '0;
      image_m  = '0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (res_valid !== 1'b0) bad++;
      end
      chk("reset_no_res_valid", bad, 0);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("post_reset_state", dbg_state, 0);
      run_job(jobs[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule
